// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Double-dabble nibble correction: nibbles at or above the threshold get the add.
  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;

  // Number of decimal digits needed to show 2^w - 1 (valid for 1 <= w <= 63).
  function automatic int unsigned min_digits(input int unsigned w);
    longint unsigned max_val;
    int unsigned     digits;
    max_val = (64'd1 << w) - 64'd1;
    digits  = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      digits  = digits + 1;
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit add-3 correction applied before each double-dabble shift.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  // A digit <= 9 plus 3 stays within 4 bits, so no carry is lost.
  always_comb begin
    adjusted = nibble;
    if (nibble >= 4'(BCD_ADJ_THRESH)) begin
      adjusted = nibble + 4'(BCD_ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock,
// with valid/ready on the input and a one-cycle valid pulse on the output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          bin_in,
  output logic                  out_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ScrW = BcdW + W;
  localparam int unsigned CntW = $clog2(W + 1);

  // Reject configurations whose digit field cannot hold the largest input.
  if (W < 1 || W > 63) begin : gen_bad_width
    $error("bin2bcd_seq: W must be in 1..63");
  end else if (DIGITS < min_digits(W)) begin : gen_bad_digits
    $error("bin2bcd_seq: DIGITS too small for W");
  end

  state_e            state_q, state_d;
  logic [ScrW-1:0]   scratch_q, scratch_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;

  logic [BcdW-1:0]   bcd_adj;
  logic [ScrW-1:0]   shifted;
  logic              last_shift;

  // Per-digit add-3 correction on the BCD field of the scratch register.
  for (genvar i = 0; i < DIGITS; i++) begin : gen_adj
    bcd_digit_adjust u_adj (
      .nibble   (scratch_q[W + 4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );
  end

  // Shift the corrected {BCD, bin} left; the top digit's MSB falls off (always 0).
  assign shifted    = {bcd_adj[BcdW-2:0], scratch_q[W-1:0], 1'b0};
  assign last_shift = (cnt_q == CntW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)   state_d = StShift;
      StShift: if (last_shift) state_d = StDone;
      StDone:                  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StShift: busy     = 1'b1;
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: load on accept, shift while converting, publish on last shift.
  always_comb begin
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          scratch_d = {{BcdW{1'b0}}, bin_in};
          cnt_d     = CntW'(W);
        end
      end
      StShift: begin
        scratch_d = shifted;
        cnt_d     = cnt_q - CntW'(1);
        if (last_shift) begin
          bcd_d = shifted[ScrW-1 -: BcdW];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; bcd_q only changes when a full result is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (W=8, DIGITS=3).
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin_in;
  logic        out_valid;
  logic        busy;
  logic [11:0] bcd_out;

  int          checks;
  int          errors;
  logic [11:0] prev;

  bin2bcd_seq #(
    .W      (8),
    .DIGITS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .busy      (busy),
    .bcd_out   (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge with the DUT idle. Accepts v, checks the held value
  // while busy, 8-edge latency, the result, and the single-cycle pulse.
  task automatic conv(input logic [7:0] v, input logic [11:0] exp, input string tag);
    int k;
    in_valid = 1'b1;
    bin_in   = v;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    check({tag, "_ready_drop"}, 32'(in_ready), 32'd0);
    while (!out_valid && k < 20) begin
      check({tag, "_hold"}, 32'(bcd_out), 32'(prev));
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 8);
    check({tag, "_result"}, 32'(bcd_out), 32'(exp));
    prev = exp;
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int  seen;
    logic [11:0] e;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'h000);
    prev = 12'h000;

    // Max value, zero, and multiplier's 15*15.
    conv(8'd255, 12'h255, "max");
    conv(8'd0,   12'h000, "zero");
    conv(8'd225, 12'h225, "p225");

    // Back-to-back with in_valid held high: accepts 10 cycles apart.
    in_valid = 1'b1;
    bin_in   = 8'd99;
    @(negedge clk);
    bin_in = 8'd100;
    for (int t = 0; t <= 19; t++) begin
      check("b2b_ready", 32'(in_ready), 32'(t == 9 || t == 19));
      check("b2b_valid", 32'(out_valid), 32'(t == 8 || t == 18));
      if (t == 8)  check("b2b_res99", 32'(bcd_out), 32'h099);
      if (t == 18) check("b2b_res100", 32'(bcd_out), 32'h100);
      if (t == 10) in_valid = 1'b0;
      @(negedge clk);
    end
    prev = 12'h100;

    // Operand changes mid-conversion are ignored.
    in_valid = 1'b1;
    bin_in   = 8'd128;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    bin_in = 8'd7;
    seen = 0;
    while (!out_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("chg_latency", seen, 7);
    check("chg_result", 32'(bcd_out), 32'h128);
    @(negedge clk);
    prev = 12'h128;

    // Reset mid-conversion of 200.
    in_valid = 1'b1;
    bin_in   = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd", 32'(bcd_out), 32'h000);
    seen = 0;
    repeat (12) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("midrst_no_pulse", seen, 0);
    prev = 12'h000;
    conv(8'd42, 12'h042, "p42");

    // Reset and in_valid on the same edge: operand dropped.
    rst      = 1'b1;
    in_valid = 1'b1;
    bin_in   = 8'd9;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rstv_ready", 32'(in_ready), 32'd1);
    check("rstv_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (12) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("rstv_no_pulse", seen, 0);
    check("rstv_bcd", 32'(bcd_out), 32'h000);
    prev = 12'h000;

    // Full sweep against a decimal reference.
    for (int v = 0; v < 256; v++) begin
      e = ref_bcd(v);
      conv(8'(v), e, "sweep");
      check("sweep_d0", 32'(bcd_out[3:0] <= 4'd9), 32'd1);
      check("sweep_d1", 32'(bcd_out[7:4] <= 4'd9), 32'd1);
      check("sweep_d2", 32'(bcd_out[11:8] <= 4'd9), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
